// File: rtl/bnn_pkg.sv
// bnn_pkg: shared types, sizes and helpers for the binarized network datapath.
package bnn_pkg;

  localparam int unsigned N_CLASS = 10;
  localparam int unsigned ACC_W   = 10;

  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, DONE} fc_state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  // +1 when up is set, -1 otherwise; clamps at the signed range ends.
  function automatic logic signed [ACC_W-1:0] sat_pm1(input logic signed [ACC_W-1:0] a,
                                                      input logic                      up);
    logic signed [ACC_W-1:0] r;
    if (up) begin
      r = (a == ACC_MAX) ? a : a + ACC_ONE;
    end else begin
      r = (a == ACC_MIN) ? a : a - ACC_ONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_scheduler_if.sv
// fc_scheduler_if: activation stream, weight-memory port and result bus of the FC scheduler.
// FC_BIAS_EN adds the per-class fc_bias input.
interface fc_scheduler_if #(
  parameter int unsigned N_IN = 121,
  parameter int unsigned AW   = $clog2(N_IN)
) ();
  import bnn_pkg::*;

  logic                       start;
  logic                       act_bit;
  logic                       act_valid;
  logic                       act_ready;
  logic                       w_rd;
  logic [AW-1:0]              w_addr;
  logic [N_CLASS-1:0]         w_data;
  logic [N_CLASS*ACC_W-1:0]   fc_result;
  logic                       fc_result_valid;
  logic [N_CLASS-1:0]         classes;
  logic                       done;
`ifdef FC_BIAS_EN
  logic [N_CLASS*ACC_W-1:0]   fc_bias;

  modport slave (
    input  start, act_bit, act_valid, w_data, fc_bias,
    output act_ready, w_rd, w_addr, fc_result, fc_result_valid, classes, done
  );
  modport master (
    output start, act_bit, act_valid, w_data, fc_bias,
    input  act_ready, w_rd, w_addr, fc_result, fc_result_valid, classes, done
  );
`else
  modport slave (
    input  start, act_bit, act_valid, w_data,
    output act_ready, w_rd, w_addr, fc_result, fc_result_valid, classes, done
  );
  modport master (
    output start, act_bit, act_valid, w_data,
    input  act_ready, w_rd, w_addr, fc_result, fc_result_valid, classes, done
  );
`endif

endinterface

// File: rtl/fc_argmax.sv
// fc_argmax: sequential argmax over a packed signed accumulator bus, one class per cycle.
// Strict > keeps the lowest index on ties.
module fc_argmax #(
  parameter int unsigned N_CLASS = 10,
  parameter int unsigned ACC_W   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_start,
  input  logic [N_CLASS*ACC_W-1:0] i_acc,
  output logic                     o_done,
  output logic [N_CLASS-1:0]       o_onehot
);

  localparam int unsigned IW = $clog2(N_CLASS);

  logic                    r_busy;
  logic                    r_done;
  logic [IW-1:0]           r_k;
  logic [IW-1:0]           r_best_idx;
  logic signed [ACC_W-1:0] r_best;
  logic [N_CLASS-1:0]      r_onehot;

  logic                    w_active;
  logic                    w_last;
  logic                    w_gt;
  logic [IW-1:0]           w_k;
  logic [IW-1:0]           w_base_idx;
  logic [IW-1:0]           w_win_idx;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_cand;
  logic signed [ACC_W-1:0] w_win;
  logic [N_CLASS-1:0]      w_onehot;

  // Compare stage: the start cycle seeds best with class 0 and already compares class 1.
  always_comb begin
    w_active   = i_start | r_busy;
    w_k        = i_start ? IW'(1) : r_k;
    w_base     = i_start ? $signed(i_acc[ACC_W-1:0]) : r_best;
    w_base_idx = i_start ? '0 : r_best_idx;
    w_cand     = $signed(i_acc[w_k*ACC_W +: ACC_W]);
    w_gt       = w_cand > w_base;
    w_win      = w_gt ? w_cand : w_base;
    w_win_idx  = w_gt ? w_k : w_base_idx;
    w_last     = (w_k == IW'(N_CLASS - 1));
    w_onehot   = '0;
    for (int i = 0; i < int'(N_CLASS); i++) begin
      w_onehot[i] = (w_win_idx == IW'(i));
    end
  end

  // Running best, compare index and held one-hot result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_k        <= '0;
      r_best_idx <= '0;
      r_best     <= '0;
      r_onehot   <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_clr) begin
        r_busy   <= 1'b0;
        r_k      <= '0;
        r_onehot <= '0;
      end else if (w_active) begin
        r_best     <= w_win;
        r_best_idx <= w_win_idx;
        r_k        <= w_last ? '0 : w_k + IW'(1);
        r_busy     <= ~w_last;
        if (w_last) begin
          r_onehot <= w_onehot;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign o_done   = r_done;
  assign o_onehot = r_onehot;

endmodule

// File: rtl/fc_scheduler.sv
// fc_scheduler: streams binarized activations, issues one weight read per activation,
// accumulates XNOR +/-1 votes per class with saturation and runs a sequential argmax.
// Optional FC_BIAS_EN: accumulators start from the fc_bias input instead of zero.
module fc_scheduler
  import bnn_pkg::*;
#(
  parameter int unsigned N_IN = 121,
  parameter int unsigned AW   = $clog2(N_IN)
) (
  input logic           clk,
  input logic           rst,
  fc_scheduler_if.slave bus
);

  // Counter must be able to hold N_IN itself, one past the last address.
  localparam int unsigned    CW      = $clog2(N_IN + 1);
  localparam logic [CW-1:0]  CNT_END = CW'(N_IN);

  fc_state_t               r_state;
  fc_state_t               w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic                    r_act;
  logic                    r_pend;
  logic                    r_fc_valid;
  logic signed [ACC_W-1:0] r_acc [N_CLASS];

  logic                    w_ready;
  logic                    w_xfer;
  logic                    w_last_acc;
  logic                    w_frame_start;
  logic                    w_argmax_done;
  logic [N_CLASS-1:0]      w_classes;

  assign w_frame_start = (r_state == IDLE) && bus.start;
  // The pending accumulate that follows the N_IN-th transfer closes the frame.
  assign w_last_acc    = r_pend && (r_cnt == CNT_END);

  // Next-state and handshake/weight-read outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_xfer      = 1'b0;
    unique case (r_state)
      IDLE:    if (bus.start) w_state_nxt = ACCUM;
      ACCUM: begin
        w_ready = (r_cnt < CNT_END);
        w_xfer  = w_ready && bus.act_valid;
        if (w_last_acc) w_state_nxt = ARGMAX;
      end
      ARGMAX:  if (w_argmax_done) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    bus.act_ready = w_ready;
    bus.w_rd      = w_xfer;
    bus.w_addr    = r_cnt[AW-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Input counter, activation pipeline register and saturating accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_act      <= 1'b0;
      r_pend     <= 1'b0;
      r_fc_valid <= 1'b0;
      for (int k = 0; k < int'(N_CLASS); k++) r_acc[k] <= '0;
    end else begin
      r_pend     <= w_xfer;
      r_fc_valid <= w_last_acc;
      if (w_xfer) begin
        r_act <= bus.act_bit;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_frame_start) begin
        r_cnt <= '0;
        for (int k = 0; k < int'(N_CLASS); k++) begin
`ifdef FC_BIAS_EN
          r_acc[k] <= $signed(bus.fc_bias[k*ACC_W +: ACC_W]);
`else
          r_acc[k] <= '0;
`endif
        end
      end else if (r_pend) begin
        // w_data answers the read issued with the activation now held in r_act.
        for (int k = 0; k < int'(N_CLASS); k++) begin
          r_acc[k] <= sat_pm1(r_acc[k], r_act ~^ bus.w_data[k]);
        end
      end
    end
  end

  // Pack the accumulators onto the result bus.
  always_comb begin
    bus.fc_result = '0;
    for (int k = 0; k < int'(N_CLASS); k++) begin
      bus.fc_result[k*ACC_W +: ACC_W] = r_acc[k];
    end
  end

  fc_argmax #(
    .N_CLASS (N_CLASS),
    .ACC_W   (ACC_W)
  ) u_argmax (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_frame_start),
    .i_start  (r_fc_valid),
    .i_acc    (bus.fc_result),
    .o_done   (w_argmax_done),
    .o_onehot (w_classes)
  );

  assign bus.fc_result_valid = r_fc_valid;
  assign bus.classes         = w_classes;
  assign bus.done            = w_argmax_done;

endmodule

// File: tb/tb_fc_scheduler.sv
// tb_fc_scheduler: scoreboard bench for fc_scheduler with a behavioural weight memory.
module tb_fc_scheduler;
  import bnn_pkg::*;

  localparam int N_IN = 121;
  localparam int NC   = N_CLASS;
  localparam int AWD  = ACC_W;
  localparam int RW   = N_CLASS * ACC_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fc_scheduler_if #(.N_IN(N_IN)) bus ();

  fc_scheduler #(.N_IN(N_IN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_fcv = 0;
  int n_done = 0;

  logic [NC-1:0] w_mem  [N_IN];
  bit            tb_act [N_IN];
  int            bias   [NC];

  logic [RW-1:0] q_res  [$];
  logic [NC-1:0] q_cls  [$];
  int            q_addr [$];

  // Weight memory: data one cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    if (bus.w_rd === 1'b1) bus.w_data <= w_mem[bus.w_addr];
    else                   bus.w_data <= NC'($urandom);
  end

  // Observe reads and output pulses.
  always @(posedge clk) begin
    if (bus.w_rd === 1'b1) q_addr.push_back(int'(bus.w_addr));
    if (bus.fc_result_valid === 1'b1) n_fcv <= n_fcv + 1;
    if (bus.done === 1'b1) n_done <= n_done + 1;
  end

  task automatic drive_bias();
`ifdef FC_BIAS_EN
    for (int k = 0; k < NC; k++) bus.fc_bias[k*AWD +: AWD] = AWD'(bias[k]);
`endif
  endtask

  // Independent reference: clamped +/-1 votes, then first-maximum argmax.
  task automatic push_expected();
    int            acc [NC];
    int            best;
    int            bi;
    logic [RW-1:0] res;
    logic [NC-1:0] cls;
    for (int k = 0; k < NC; k++) begin
      acc[k] = bias[k];
      for (int i = 0; i < N_IN; i++) begin
        if (tb_act[i] == w_mem[i][k]) acc[k] = acc[k] + 1;
        else                          acc[k] = acc[k] - 1;
        if (acc[k] > 511)  acc[k] = 511;
        if (acc[k] < -512) acc[k] = -512;
      end
      res[k*AWD +: AWD] = AWD'(acc[k]);
    end
    best = acc[0];
    bi   = 0;
    for (int k = 1; k < NC; k++) begin
      if (acc[k] > best) begin
        best = acc[k];
        bi   = k;
      end
    end
    cls     = '0;
    cls[bi] = 1'b1;
    q_res.push_back(res);
    q_cls.push_back(cls);
  endtask

  // One full frame; mode 0 = continuous valid, 1 = every other cycle, 2 = random gaps.
  task automatic run_frame(input int mode);
    int            i;
    int            cyc;
    int            lat;
    int            fcv0;
    int            dn0;
    int            a0;
    bit            ok;
    logic [RW-1:0] er;
    logic [NC-1:0] ec;
    push_expected();
    drive_bias();
    fcv0 = n_fcv;
    dn0  = n_done;
    a0   = q_addr.size();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_vec++;
    if (bus.act_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_start: got %b want 1", bus.act_ready);
    end
    i   = 0;
    cyc = 0;
    while (i < N_IN && cyc < 10 * N_IN) begin
      bus.act_valid = (mode == 0) || (mode == 1 && cyc % 2 == 0) ||
                      (mode == 2 && $urandom_range(1) == 1);
      bus.act_bit   = bus.act_valid ? tb_act[i] : 1'($urandom);
      if (bus.act_valid && bus.act_ready) i++;
      @(negedge clk);
      cyc++;
    end
    bus.act_valid = 1'b0;
    n_vec++;
    if (i != N_IN) begin
      n_err++;
      $display("FAIL feed_transfers: got %0d want %0d", i, N_IN);
    end
    lat = 0;
    while (bus.fc_result_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat != 1) begin
      n_err++;
      $display("FAIL result_latency: got %0d want 1", lat);
    end
    er = q_res.pop_front();
    ec = q_cls.pop_front();
    n_vec++;
    if (bus.fc_result !== er) begin
      n_err++;
      $display("FAIL fc_result: got %h want %h", bus.fc_result, er);
    end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat != NC - 1) begin
      n_err++;
      $display("FAIL done_latency: got %0d want %0d", lat, NC - 1);
    end
    n_vec++;
    if (bus.classes !== ec) begin
      n_err++;
      $display("FAIL classes: got %b want %b", bus.classes, ec);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.classes !== ec || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL classes_held: got %b done %b want %b done 0", bus.classes, bus.done, ec);
    end
    n_vec++;
    if (n_fcv - fcv0 != 1 || n_done - dn0 != 1) begin
      n_err++;
      $display("FAIL pulse_count: got fcv %0d done %0d want 1 1", n_fcv - fcv0, n_done - dn0);
    end
    ok = (q_addr.size() - a0 == N_IN);
    for (int j = 0; ok && j < N_IN; j++) if (q_addr[a0 + j] != j) ok = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL w_rd_sequence: got %0d reads want %0d in order 0..%0d",
               q_addr.size() - a0, N_IN, N_IN - 1);
    end
  endtask

  task automatic set_class_only(input int c);
    for (int i = 0; i < N_IN; i++) begin
      tb_act[i]    = 1'b1;
      w_mem[i]     = '0;
      w_mem[i][c]  = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.act_ready, bus.w_rd, bus.fc_result_valid, bus.done} !== 4'b0 ||
        bus.w_addr !== '0 || bus.fc_result !== '0 || bus.classes !== '0) begin
      n_err++;
      $display("FAIL reset_values: got rdy %b rd %b addr %0d res %h frv %b cls %b done %b want 0",
               bus.act_ready, bus.w_rd, bus.w_addr, bus.fc_result, bus.fc_result_valid,
               bus.classes, bus.done);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.act_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_not_ready: got %b want 0", bus.act_ready);
    end
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < N_IN; i++) begin
      tb_act[i] = 1'b1;
      w_mem[i]  = '1;
    end
    run_frame(0);
  endtask

  task automatic test_one_class();
    set_class_only(7);
    run_frame(0);
  endtask

  task automatic test_gapped();
    set_class_only(7);
    run_frame(1);
  endtask

  task automatic test_start_reset();
    int i;
    int cyc;
    int a0;
    bit ok;
    set_class_only(4);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_vec++;
    if (bus.classes !== '0) begin
      n_err++;
      $display("FAIL classes_cleared_on_start: got %b want 0", bus.classes);
    end
    a0  = q_addr.size();
    i   = 0;
    cyc = 0;
    while (i < 50 && cyc < 200) begin
      bus.act_valid = 1'b1;
      bus.act_bit   = 1'b1;
      bus.start     = (i == 30);
      if (bus.act_valid && bus.act_ready) i++;
      @(negedge clk);
      cyc++;
    end
    bus.start     = 1'b0;
    bus.act_valid = 1'b0;
    n_vec++;
    if (bus.w_addr !== 7'd50 || bus.act_ready !== 1'b1) begin
      n_err++;
      $display("FAIL start_ignored: got addr %0d rdy %b want 50 1", bus.w_addr, bus.act_ready);
    end
    ok = (q_addr.size() - a0 == 50);
    for (int j = 0; ok && j < 50; j++) if (q_addr[a0 + j] != j) ok = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL partial_reads: got %0d reads want 50 in order", q_addr.size() - a0);
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.act_ready, bus.w_rd, bus.fc_result_valid, bus.done} !== 4'b0 ||
        bus.w_addr !== '0 || bus.fc_result !== '0 || bus.classes !== '0) begin
      n_err++;
      $display("FAIL mid_frame_reset: got rdy %b addr %0d res %h cls %b want 0",
               bus.act_ready, bus.w_addr, bus.fc_result, bus.classes);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.act_ready !== 1'b0 || bus.fc_result !== '0) begin
      n_err++;
      $display("FAIL idle_after_reset: got rdy %b res %h want 0 0", bus.act_ready, bus.fc_result);
    end
    set_class_only(2);
    run_frame(0);
  endtask

  task automatic test_tie();
    for (int i = 0; i < N_IN; i++) begin
      tb_act[i]   = 1'b1;
      w_mem[i]    = NC'($urandom);
      w_mem[i][3] = 1'b1;
      w_mem[i][5] = 1'b1;
      if (i == 0) w_mem[i] = NC'(10'b0000101000);
    end
    run_frame(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < N_IN; i++) begin
      tb_act[i] = 1'($urandom);
      w_mem[i]  = NC'($urandom);
    end
    run_frame(2);
  endtask

  // start and act_valid held high across two frames.
  task automatic test_back_to_back();
    int            rise [2];
    int            nr;
    int            frames;
    int            a0;
    int            n;
    logic          prev;
    logic [RW-1:0] er;
    logic [NC-1:0] ec;
    for (int i = 0; i < N_IN; i++) begin
      tb_act[i] = 1'b1;
      w_mem[i]  = NC'($urandom);
    end
    push_expected();
    push_expected();
    drive_bias();
    a0      = q_addr.size();
    nr      = 0;
    frames  = 0;
    prev    = 1'b0;
    rise[0] = 0;
    rise[1] = 0;
    n       = 0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.act_valid = 1'b1;
    bus.act_bit   = 1'b1;
    while (frames < 2 && n < 400) begin
      if (bus.act_ready === 1'b1 && prev === 1'b0 && nr < 2) begin
        rise[nr] = n;
        nr++;
      end
      prev = bus.act_ready;
      if (bus.fc_result_valid === 1'b1) begin
        er = q_res.pop_front();
        n_vec++;
        if (bus.fc_result !== er) begin
          n_err++;
          $display("FAIL b2b_result: got %h want %h", bus.fc_result, er);
        end
      end
      if (bus.done === 1'b1) begin
        ec = q_cls.pop_front();
        frames++;
        n_vec++;
        if (bus.classes !== ec) begin
          n_err++;
          $display("FAIL b2b_classes: got %b want %b", bus.classes, ec);
        end
      end
      if (frames < 2) begin
        @(negedge clk);
        n++;
      end
    end
    bus.start     = 1'b0;
    bus.act_valid = 1'b0;
    n_vec++;
    if (frames != 2 || rise[1] - rise[0] != N_IN + NC + 3) begin
      n_err++;
      $display("FAIL b2b_period: got frames %0d period %0d want 2 %0d",
               frames, rise[1] - rise[0], N_IN + NC + 3);
    end
    n_vec++;
    if (q_addr.size() - a0 != 2 * N_IN) begin
      n_err++;
      $display("FAIL b2b_reads: got %0d want %0d", q_addr.size() - a0, 2 * N_IN);
    end
    repeat (3) @(negedge clk);
  endtask

`ifdef FC_BIAS_EN
  task automatic test_bias();
    for (int i = 0; i < N_IN; i++) begin
      tb_act[i] = 1'b1;
      w_mem[i]  = '1;
    end
    bias[2] = 500;
    run_frame(0);
    bias[2] = 0;
    drive_bias();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.act_valid = 1'b0;
    bus.act_bit   = 1'b0;
    for (int k = 0; k < NC; k++) bias[k] = 0;
    drive_bias();
    test_reset();
    test_all_ones();
    test_one_class();
    test_gapped();
    test_start_reset();
    test_tie();
    test_random();
    test_back_to_back();
`ifdef FC_BIAS_EN
    test_bias();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
